// File: rtl/viterbi_pkg.sv
// Shared constants and helpers for the K=9 rate-1/2 hard-decision Viterbi decoder.
package viterbi_pkg;
   localparam int           K          = 9;
   localparam logic [K-1:0] G0         = 9'o753;
   localparam logic [K-1:0] G1         = 9'o561;
   localparam int           WD_CODE    = 2;
   localparam int           WD_PM      = 8;
   localparam int           DEPTH      = 40;
   localparam int           SYM_CYCLES = 8;
   localparam int           NSTATES    = 2**(K-1);

   function automatic logic parity(input logic [31:0] v);
      return ^v;
   endfunction
endpackage

// File: rtl/viterbi_acs.sv
// Add-compare-select for one trellis state, using modulo path-metric comparison.
module viterbi_acs import viterbi_pkg::*; #(
   parameter int WD_PM = viterbi_pkg::WD_PM
) (
   input  logic [WD_PM-1:0] pm0_i,
   input  logic [WD_PM-1:0] pm1_i,
   input  logic [1:0]       bm0_i,
   input  logic [1:0]       bm1_i,
   output logic [WD_PM-1:0] pm_o,
   output logic             dec_o
);
   logic [WD_PM-1:0] cand0;
   logic [WD_PM-1:0] cand1;
   logic [WD_PM-1:0] diff;

   always_comb begin
      cand0 = pm0_i + WD_PM'(bm0_i);
      cand1 = pm1_i + WD_PM'(bm1_i);
      // Sign of the wrapped difference stays valid as long as metric spread < 2^(WD_PM-1)
      diff  = cand1 - cand0;
      dec_o = diff[WD_PM-1];
      pm_o  = dec_o ? cand1 : cand0;
   end
endmodule

// File: rtl/viterbi_decoder.sv
// Hard-decision Viterbi decoder: parallel ACS over all states, register-exchange survivors.
module viterbi_decoder import viterbi_pkg::*; #(
   parameter int           K          = viterbi_pkg::K,
   parameter logic [K-1:0] G0         = viterbi_pkg::G0,
   parameter logic [K-1:0] G1         = viterbi_pkg::G1,
   parameter int           SYM_CYCLES = viterbi_pkg::SYM_CYCLES,
   parameter int           DEPTH      = viterbi_pkg::DEPTH,
   parameter int           WD_CODE    = viterbi_pkg::WD_CODE,
   parameter int           WD_PM      = viterbi_pkg::WD_PM
) (
   input  logic               CLOCK,
   input  logic               Reset,
   input  logic               Active,
   input  logic [WD_CODE-1:0] Code,
   output logic               DecodeOut
);
   localparam int               NS      = 2**(K-1);
   localparam int               CW      = $clog2(SYM_CYCLES + 1);
   localparam int               VW      = $clog2(DEPTH + 1);
   localparam logic [WD_PM-1:0] PM_INIT = WD_PM'(2**(WD_PM-2));

   logic [NS-1:0][WD_PM-1:0] pm_q, pm_d, pm_acs;
   logic [NS-1:0][DEPTH-1:0] surv_q, surv_d, surv_nxt;
   logic [NS-1:0]            dec;
   logic [CW-1:0]            cnt_q, cnt_d;
   logic [VW-1:0]            vcnt_q, vcnt_d;
   logic                     out_q, out_d;
   logic                     sym_en;

   // State n = {prev[K-3:0], bit}: predecessors differ only in their MSB, branch bit is n[0]
   for (genvar s = 0; s < NS; s++) begin : g_st
      localparam logic [K-2:0] P0 = (K-1)'(s >> 1);
      localparam logic [K-2:0] P1 = P0 | (K-1)'(1 << (K-2));
      localparam logic         B  = (s % 2) == 1;
      localparam logic [1:0]   E0 = {parity(32'(G0 & {B, P0})), parity(32'(G1 & {B, P0}))};
      localparam logic [1:0]   E1 = {parity(32'(G0 & {B, P1})), parity(32'(G1 & {B, P1}))};

      logic [1:0] bm0;
      logic [1:0] bm1;

      assign bm0 = {1'b0, Code[1] ^ E0[1]} + {1'b0, Code[0] ^ E0[0]};
      assign bm1 = {1'b0, Code[1] ^ E1[1]} + {1'b0, Code[0] ^ E1[0]};

      viterbi_acs #(.WD_PM(WD_PM)) u_acs (
         .pm0_i (pm_q[P0]),
         .pm1_i (pm_q[P1]),
         .bm0_i (bm0),
         .bm1_i (bm1),
         .pm_o  (pm_acs[s]),
         .dec_o (dec[s])
      );

      assign surv_nxt[s] = {(dec[s] ? surv_q[P1][DEPTH-2:0] : surv_q[P0][DEPTH-2:0]), B};
   end

   always_comb begin
      sym_en = Active && (cnt_q == CW'(SYM_CYCLES - 1));
      cnt_d  = cnt_q;
      vcnt_d = vcnt_q;
      out_d  = out_q;
      pm_d   = pm_q;
      surv_d = surv_q;
      if (Active) cnt_d = sym_en ? '0 : cnt_q + CW'(1);
      if (sym_en) begin
         pm_d   = pm_acs;
         surv_d = surv_nxt;
         // Pre-update state-0 path gives exactly DEPTH symbols of latency
         out_d  = (vcnt_q == VW'(DEPTH)) ? surv_q[0][DEPTH-1] : 1'b0;
         if (vcnt_q != VW'(DEPTH)) vcnt_d = vcnt_q + VW'(1);
      end
   end

   always_ff @(posedge CLOCK) begin
      if (Reset) begin
         for (int i = 0; i < NS; i++) pm_q[i] <= (i == 0) ? '0 : PM_INIT;
         surv_q <= '0;
         cnt_q  <= '0;
         vcnt_q <= '0;
         out_q  <= 1'b0;
      end else begin
         pm_q   <= pm_d;
         surv_q <= surv_d;
         cnt_q  <= cnt_d;
         vcnt_q <= vcnt_d;
         out_q  <= out_d;
      end
   end

   assign DecodeOut = out_q;
endmodule

// File: tb/tb_viterbi_decoder.sv
// Directed bench: reference encoder feeds the decoder; output must equal the input delayed DEPTH symbols.
module tb_viterbi_decoder;
   import viterbi_pkg::*;

   localparam logic [14:0] PAT = 15'b111110001010110;

   logic       clk = 1'b0;
   logic       rst;
   logic       act;
   logic [1:0] code;
   logic       dout;

   int         n_chk  = 0;
   int         n_pass = 0;
   logic [7:0] enc_s;
   logic       hist[$];

   always #5 clk = ~clk;

   viterbi_decoder dut (
      .CLOCK     (clk),
      .Reset     (rst),
      .Active    (act),
      .Code      (code),
      .DecodeOut (dout)
   );

   function automatic logic [1:0] enc_out(input logic b, input logic [7:0] s);
      logic [8:0] r;
      r = {b, s};
      return {^(r & 9'o753), ^(r & 9'o561)};
   endfunction

   function automatic logic expected();
      int n;
      n = hist.size() - 1;
      return (n >= DEPTH) ? hist[n - DEPTH] : 1'b0;
   endfunction

   task automatic check(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: DecodeOut=%0b expected %0b (symbol %0d)", tag, obs, exp, hist.size() - 1);
   endtask

   task automatic restart();
      enc_s = '0;
      hist.delete();
   endtask

   task automatic push_sym(input logic b, input logic [1:0] err);
      code  = enc_out(b, enc_s) ^ err;
      enc_s = {enc_s[6:0], b};
      hist.push_back(b);
   endtask

   task automatic send(input logic b, input logic [1:0] err, input string tag);
      push_sym(b, err);
      act = 1'b1;
      repeat (SYM_CYCLES) @(posedge clk);
      #1;
      check(tag, dout, expected());
   endtask

   // Active drops after `pre` counted clocks of a symbol; Code is garbage while idle
   task automatic send_pause(input logic b, input int pre, input int idle);
      logic       prev;
      logic [1:0] good;
      prev = expected();
      push_sym(b, 2'b00);
      good = code;
      act  = 1'b1;
      repeat (pre) @(posedge clk);
      #1;
      act  = 1'b0;
      code = ~good;
      repeat (idle) @(posedge clk);
      #1;
      check("freeze", dout, prev);
      code = good;
      act  = 1'b1;
      repeat (SYM_CYCLES - pre - 1) @(posedge clk);
      #1;
      check("partial_hold", dout, prev);
      @(posedge clk);
      #1;
      check("resume", dout, expected());
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset", dout, 1'b0);
      rst = 1'b0;
      restart();
   endtask

   initial begin
      rst  = 1'b1;
      act  = 1'b0;
      code = 2'b00;
      restart();
      repeat (2) @(posedge clk);
      do_reset();

      for (int i = 0; i < 200; i++) send(1'b0, 2'b00, "all_zero");
      do_reset();

      // Symbol 45 is paused; its output (PAT[5]=0) differs from the previous one (PAT[4]=1)
      for (int i = 0; i < 45; i++) send(PAT[14 - (i % 15)], 2'b00, "pattern");
      send_pause(PAT[14 - (45 % 15)], 3, 3 * SYM_CYCLES);
      for (int i = 46; i < 120; i++) send(PAT[14 - (i % 15)], 2'b00, "pattern");
      do_reset();

      for (int i = 0; i < 120; i++) begin
         logic [1:0] e;
         e = (i == 3)  ? 2'b10 :
             (i == 9)  ? 2'b01 :
             (i == 60) ? 2'b10 :
             (i == 80) ? 2'b01 : 2'b00;
         send(PAT[14 - (i % 15)], e, "pattern_err");
      end

      // Reset lands mid-symbol while Active is high; last output before it was PAT[4]=1
      push_sym(1'b1, 2'b00);
      act = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("reset_mid", dout, 1'b0);
      rst = 1'b0;
      restart();
      for (int i = 0; i < 60; i++) send(PAT[14 - (i % 15)], 2'b00, "after_reset");
      do_reset();

      for (int i = 0; i < 1000; i++) send(1'($urandom_range(0, 1)), 2'b00, "random");

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
